dl_pipe_ctrl: RTL and testbench
===============================

# dl_pipe_ctrl

Pipeline sequencing controller for an N-stage in-order pipeline built from `dl_reg_en_rst` data registers. It tracks one valid bit per stage and computes a per-stage load enable from upstream valid, per-stage stall requests and downstream backpressure. It also applies partial flushes, for example a branch mispredict killing younger stages. The datapath registers stay in the instantiating stage logic; this block only drives their `en` pins and reports occupancy.

## Interface
Parameters:
- `NUM_STAGES`, default 5: number of pipeline stages; must be ≥ 2.
- `IDX_W`, default `$clog2(NUM_STAGES)`: width of `flush_stage`.

Ports:
- `clk`  input  1: clock; all state updates on rising edge.
- `rst_n`  input  1: reset; synchronous, active-low.
- `in_valid`  input  1: new item offered to stage 0.
- `in_ready`  output  1: stage 0 accepts this cycle. Transfer when `in_valid && in_ready`.
- `stall_req`  input  NUM_STAGES: bit i holds stage i's contents this cycle.
- `flush`  input  1: kill stages 0..`flush_stage` this cycle.
- `flush_stage`  input  IDX_W: highest (oldest) stage index killed. Values ≥ NUM_STAGES-1 kill all stages.
- `out_valid`  output  1: last stage presents a completed item.
- `out_ready`  input  1: consumer accepts the item from the last stage.
- `stage_en`  output  NUM_STAGES: load enable for stage i's data register.
- `stage_valid`  output  NUM_STAGES: registered valid bit per stage.
- `occupancy`  output  `$clog2(NUM_STAGES+1)`: popcount of `stage_valid`.

## Operation
- State: `v[NUM_STAGES-1:0]`, the only registers in the block. Stage 0 is the youngest stage; stage N-1 is the oldest.
- Upstream valid:
  - `up[0] = in_valid`.
  - `up[i] = v[i-1] && !stall_req[i-1]` for i > 0.
- Ready chain, evaluated combinationally from oldest to youngest:
  - `rdy[N] = out_ready`.
  - `adv[i] = v[i] && !stall_req[i] && rdy[i+1]`.
  - `rdy[i] = !v[i] || adv[i]`.
  - `stall_req[i]` on an empty stage is ignored; a bubble is always overwritable.
- Outputs and next state with no flush:
  - `stage_en[i] = rdy[i]`.
  - `v[i] <= rdy[i] ? up[i] : v[i]`.
  - `in_ready = rdy[0]`.
  - `out_valid = v[N-1] && !stall_req[N-1]`.
- Flush with k = min(`flush_stage`, N-1):
  - For j ≤ k: `v[j] <= 0` and `stage_en[j] = 0`. Flush wins over load and stall.
  - `in_ready = 0`.
  - `up[k+1]` is masked to 0. The killed item in stage k does not advance, so stage k+1 loads a bubble if `rdy[k+1]`.
  - Stages above k+1 behave normally. `out_valid` is unaffected unless k = N-1, in which case `out_valid = 0`.
- Stall on stage i with `v[i] = 1`:
  - Stages 0..i hold only while they are full. Upstream bubbles still collapse into stage i-1 and below.
  - Stage i+1 receives a bubble when it is ready.
- Reset (`rst_n = 0` at an edge): `v <= 0`. While `rst_n` is low, `stage_en`, `in_ready` and `out_valid` are forced to 0.

## Timing
- Reset values: `stage_valid = 0`, `occupancy = 0`, `out_valid = 0`. `in_ready = 1` in the first cycle after reset is released, provided no flush is asserted.
- Latency:
  - An item accepted in cycle t is in stage 0 in cycle t+1.
  - With no stalls and `out_ready` held high, `out_valid` is high in cycle t+NUM_STAGES.
- Throughput: one item per cycle when no stage stalls.
- Backpressure: `out_ready` reaches `in_ready` in the same cycle through a combinational chain. No skid buffer; zero-cycle bubble-free handshaking.
- Flush takes effect at the next edge; killed stages read `stage_valid = 0` in the following cycle.
- Simultaneous `flush` and `stall_req`: flush dominates for j ≤ k. Stall applies to stages above k.
- Simultaneous `flush` and `in_valid`: the input is not accepted (`in_ready = 0`); the producer must hold its item.
- `rst_n` low mid-operation: all in-flight items are dropped at that edge. No output handshake occurs that cycle.

## Test plan
All scenarios use NUM_STAGES = 5.
- Reset then stream:
  - Stimulus: `in_valid = 1` and `out_ready = 1` continuously from cycle 0 after reset.
  - Required response: `out_valid` first high at cycle 5, then high every cycle; `occupancy` ramps 1, 2, 3, 4, 5 and holds at 5.
- Output backpressure:
  - Stimulus: pipeline full, `out_ready = 0` for 3 cycles.
  - Required response: `stage_en = 5'b00000`, `in_ready = 0`, `stage_valid = 5'b11111` held.
  - On `out_ready = 1`: `stage_en = 5'b11111` in that same cycle.
- Mid stall with bubble insertion:
  - Stimulus: full pipeline, `stall_req[2] = 1` for 1 cycle.
  - Required response: `stage_en = 5'b11000`; next cycle `stage_valid = 5'b10111`.
- Partial flush:
  - Stimulus: full pipeline, `flush = 1`, `flush_stage = 2`, `in_valid = 1`.
  - Required response: `in_ready = 0`, `stage_en[2:0] = 0`; next cycle `stage_valid = 5'b11000`, `occupancy = 2`.
- Full flush plus stall conflict:
  - Stimulus: `flush_stage = 7` with `stall_req = 5'b11111`.
  - Required response: `out_valid = 0`; next cycle `stage_valid = 0`.
- Reset mid-stream:
  - Stimulus: drop `rst_n` for 1 cycle while the pipeline is full.
  - Required response: `stage_en`, `in_ready` and `out_valid` are 0 during reset; `stage_valid = 0` after reset; normal refill latency of 5 cycles.

Source files
------------

// File: rtl/dl_pipe_ctrl.sv
// Valid/enable sequencer for an in-order pipeline of enable-gated data registers.
// Tracks one valid bit per stage; applies stalls, output backpressure and partial flushes.
module dl_pipe_ctrl #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_STAGES-1:0]                 stall_req,
    input  logic                                  flush,
    input  logic [IDX_W-1:0]                      flush_stage,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_STAGES-1:0]                 stage_en,
    output logic [NUM_STAGES-1:0]                 stage_valid,
    output logic [$clog2(NUM_STAGES+1)-1:0]       occupancy
);

    localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] v_q;
    logic [NUM_STAGES-1:0] v_d;
    logic [NUM_STAGES-1:0] kill;
    logic [NUM_STAGES-1:0] up;
    logic [NUM_STAGES:0]   rdy;
    logic [OCC_W-1:0]      occ_d;

    // Any flush_stage at or beyond the last index kills every stage.
    always_comb begin
        kill = '0;
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            kill[j] = flush && (32'(flush_stage) >= j);
        end
    end

    // Items leaving a killed stage never reach the next one.
    always_comb begin
        up    = '0;
        up[0] = in_valid;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            up[i] = v_q[i-1] && !stall_req[i-1] && !kill[i-1];
        end
    end

    // Ready ripples from the consumer back to stage 0 within the cycle.
    always_comb begin
        logic        adv;
        int unsigned i;
        rdy             = '0;
        rdy[NUM_STAGES] = out_ready;
        for (int unsigned n = 0; n < NUM_STAGES; n++) begin
            i      = NUM_STAGES - 1 - n;
            adv    = v_q[i] && !stall_req[i] && rdy[i+1];
            rdy[i] = !v_q[i] || adv;
        end
    end

    always_comb begin
        v_d      = v_q;
        stage_en = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stage_en[i] = rst_n && rdy[i] && !kill[i];
            if (kill[i]) begin
                v_d[i] = 1'b0;
            end else if (rdy[i]) begin
                v_d[i] = up[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    always_comb begin
        occ_d = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            occ_d = occ_d + {{(OCC_W-1){1'b0}}, v_q[i]};
        end
    end

    assign in_ready    = rst_n && rdy[0] && !flush;
    assign out_valid   = rst_n && v_q[NUM_STAGES-1] && !stall_req[NUM_STAGES-1] && !kill[NUM_STAGES-1];
    assign stage_valid = v_q;
    assign occupancy   = occ_d;

endmodule

// File: tb/tb_dl_pipe_ctrl.sv
// Bench for dl_pipe_ctrl: directed scenarios plus random traffic against an item-slot model.
module tb_dl_pipe_ctrl;

    localparam int NS = 5;
    localparam int IW = $clog2(NS);
    localparam int OW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NS-1:0] stall_req;
    logic          flush;
    logic [IW-1:0] flush_stage;
    logic          out_valid;
    logic          out_ready;
    logic [NS-1:0] stage_en;
    logic [NS-1:0] stage_valid;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    dl_pipe_ctrl #(.NUM_STAGES(NS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush       (flush),
        .flush_stage (flush_stage),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: each stage slot holds an item id, -1 meaning empty.
    int slot  [NS];
    int nslot [NS];
    int next_id = 0;

    task automatic drive(input logic r, input logic iv, input logic [NS-1:0] st,
                         input logic fl, input int fs, input logic orr);
        int            kfl;
        logic          free;
        logic [NS-1:0] fr, mv, m_en;
        logic          m_ir, m_ov;
        rst_n = r; in_valid = iv; stall_req = st; flush = fl;
        flush_stage = IW'(fs); out_ready = orr;
        #4;
        kfl = -1;
        if (fl) kfl = (fs > NS - 1) ? NS - 1 : fs;
        fr = '0; mv = '0; m_en = '0; m_ir = 1'b0; m_ov = 1'b0;
        if (!r) begin
            for (int i = 0; i < NS; i++) nslot[i] = -1;
        end else begin
            // An occupied slot moves on only if unstalled and its destination frees up.
            free = orr;
            for (int i = NS - 1; i >= 0; i--) begin
                mv[i] = (slot[i] >= 0) && !st[i] && free;
                fr[i] = (slot[i] < 0) || mv[i];
                free  = fr[i];
            end
            for (int i = 0; i < NS; i++) m_en[i] = fr[i] && (i > kfl);
            m_ir = fr[0] && !fl;
            m_ov = (slot[NS-1] >= 0) && !st[NS-1] && (kfl != NS - 1);
            for (int i = 0; i < NS; i++) begin
                if (i <= kfl)          nslot[i] = -1;
                else if (!fr[i])       nslot[i] = slot[i];
                else if (i == 0)       nslot[i] = (iv && m_ir) ? next_id : -1;
                else                   nslot[i] = (mv[i-1] && (i - 1 > kfl)) ? slot[i-1] : -1;
            end
            if (iv && m_ir) next_id++;
        end
        check("m_stage_en", stage_en, m_en);
        check("m_in_ready", in_ready, m_ir);
        check("m_out_valid", out_valid, m_ov);
    endtask

    task automatic tick();
        logic [NS-1:0] mv;
        int            cnt;
        @(posedge clk);
        #1;
        mv = '0; cnt = 0;
        for (int i = 0; i < NS; i++) begin
            slot[i] = nslot[i];
            mv[i]   = (slot[i] >= 0);
            if (mv[i]) cnt++;
        end
        check("m_stage_valid", stage_valid, mv);
        check("m_occupancy", occupancy, cnt);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; stall_req = '0; flush = 1'b0;
        flush_stage = '0; out_ready = 1'b0;
        for (int i = 0; i < NS; i++) begin slot[i] = -1; nslot[i] = -1; end
        @(posedge clk);
        #1;

        drive(0, 1, '0, 0, 0, 1);
        check("rst_en", stage_en, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        tick();
        check("rst_stage_valid", stage_valid, 0);
        check("rst_occupancy", occupancy, 0);

        for (int c = 0; c < 8; c++) begin
            drive(1, 1, '0, 0, 0, 1);
            if (c == 0) check("first_in_ready", in_ready, 1);
            check("stream_out_valid", out_valid, c >= 5);
            check("stream_occupancy", occupancy, (c < 5) ? c : 5);
            tick();
        end

        repeat (3) begin
            drive(1, 1, '0, 0, 0, 0);
            check("bp_en", stage_en, 5'b00000);
            check("bp_in_ready", in_ready, 0);
            check("bp_stage_valid", stage_valid, 5'b11111);
            tick();
        end
        drive(1, 1, '0, 0, 0, 1);
        check("bp_release_en", stage_en, 5'b11111);
        tick();

        drive(1, 1, 5'b00100, 0, 0, 1);
        check("stall_en", stage_en, 5'b11000);
        tick();
        check("stall_stage_valid", stage_valid, 5'b10111);

        drive(1, 1, '0, 0, 0, 0);
        tick();
        check("refill_full", stage_valid, 5'b11111);

        drive(1, 1, '0, 1, 2, 0);
        check("pflush_in_ready", in_ready, 0);
        check("pflush_en_low", stage_en[2:0], 3'b000);
        tick();
        check("pflush_stage_valid", stage_valid, 5'b11000);
        check("pflush_occupancy", occupancy, 2);

        repeat (4) begin drive(1, 1, '0, 0, 0, 0); tick(); end
        check("refill2_full", stage_valid, 5'b11111);

        drive(1, 1, 5'b11111, 1, 7, 1);
        check("fflush_out_valid", out_valid, 0);
        tick();
        check("fflush_stage_valid", stage_valid, 5'b00000);

        repeat (6) begin drive(1, 1, '0, 0, 0, 1); tick(); end
        check("refill3_full", stage_valid, 5'b11111);

        drive(0, 1, '0, 0, 0, 1);
        check("midrst_en", stage_en, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        tick();
        check("midrst_stage_valid", stage_valid, 0);
        for (int c = 0; c < 6; c++) begin
            drive(1, 1, '0, 0, 0, 1);
            check("relat_out_valid", out_valid, c == 5);
            tick();
        end

        for (int n = 0; n < 3000; n++) begin
            logic [NS-1:0] st;
            for (int b = 0; b < NS; b++) st[b] = ($urandom_range(7) == 0);
            drive($urandom_range(63) != 0, $urandom_range(3) != 0, st,
                  $urandom_range(7) == 0, int'($urandom_range(7)), $urandom_range(3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
